// File: rtl/i2c_regs_pkg.sv
// Shared constants for the I2C register block: register offsets, STATUS field
// positions, the AXI OKAY response and a byte-lane merge helper.
package i2c_regs_pkg;

    localparam logic [4:0] CtrlOffset     = 5'h00;
    localparam logic [4:0] TxdataOffset   = 5'h04;
    localparam logic [4:0] PrescaleOffset = 5'h08;
    localparam logic [4:0] AuxOffset      = 5'h0C;
    localparam logic [4:0] StatusOffset   = 5'h10;

    localparam int unsigned StatusRxLsb     = 0;
    localparam int unsigned StatusBusyBit   = 8;
    localparam int unsigned StatusAckErrBit = 9;

    localparam logic [1:0] RespOkay = 2'b00;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/i2c_regs_axil_slave.sv
// AXI4-Lite register front end for an I2C engine: four R/W registers, a live
// STATUS word and a one-cycle start strobe on CTRL[0] writes.
module i2c_regs_axil_slave
    import i2c_regs_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     ctrl_reg,
    output logic [31:0]                     txdata_reg,
    output logic [31:0]                     prescale_reg,
    output logic [31:0]                     aux_reg,
    output logic                            start_pulse,
    input  logic                            i2c_busy,
    input  logic                            i2c_ack_err,
    input  logic [7:0]                      i2c_rx_data
);

    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Write channel
    logic                            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                            awready_q, awready_d, wready_q, wready_d;
    logic                            bvalid_q, bvalid_d, start_q, start_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d, wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d, wr_strb;
    logic [31:0]                     ctrl_q, ctrl_d, txdata_q, txdata_d;
    logic [31:0]                     prescale_q, prescale_d, aux_q, aux_d;
    logic                            aw_hs, w_hs, commit;

    always_comb begin
        aw_hs   = s00_axi_awvalid & awready_q;
        w_hs    = s00_axi_wvalid & wready_q;
        wr_addr = aw_held_q ? awaddr_q : s00_axi_awaddr;
        wr_data = w_held_q ? wdata_q : s00_axi_wdata;
        wr_strb = w_held_q ? wstrb_q : s00_axi_wstrb;
        // Commit on the edge that completes the AW/W pair, so the new value and
        // bvalid become visible together in the following cycle.
        commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

        awaddr_d   = aw_hs ? s00_axi_awaddr : awaddr_q;
        wdata_d    = w_hs ? s00_axi_wdata : wdata_q;
        wstrb_d    = w_hs ? s00_axi_wstrb : wstrb_q;
        aw_held_d  = aw_held_q | aw_hs;
        w_held_d   = w_held_q | w_hs;
        bvalid_d   = bvalid_q & ~s00_axi_bready;
        ctrl_d     = ctrl_q;
        txdata_d   = txdata_q;
        prescale_d = prescale_q;
        aux_d      = aux_q;
        start_d    = 1'b0;

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            unique case ({wr_addr[4:2], 2'b00})
                CtrlOffset: begin
                    ctrl_d  = apply_strb(ctrl_q, wr_data, wr_strb);
                    start_d = wr_strb[0] & wr_data[0] & ~i2c_busy;
                end
                TxdataOffset:   txdata_d   = apply_strb(txdata_q, wr_data, wr_strb);
                PrescaleOffset: prescale_d = apply_strb(prescale_q, wr_data, wr_strb);
                AuxOffset:      aux_d      = apply_strb(aux_q, wr_data, wr_strb);
                default: ;
            endcase
        end

        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            start_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ctrl_q     <= '0;
            txdata_q   <= '0;
            prescale_q <= '0;
            aux_q      <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            start_q    <= start_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ctrl_q     <= ctrl_d;
            txdata_q   <= txdata_d;
            prescale_q <= prescale_d;
            aux_q      <= aux_d;
        end
    end

    // Read channel
    logic                          arready_q, arready_d, rvalid_q, rvalid_d, ar_hs;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]                   status, rd_mux;

    always_comb begin
        status                          = '0;
        status[StatusRxLsb +: 8]        = i2c_rx_data;
        status[StatusBusyBit]           = i2c_busy;
        status[StatusAckErrBit]         = i2c_ack_err;

        rd_mux = '0;
        unique case ({s00_axi_araddr[4:2], 2'b00})
            CtrlOffset:     rd_mux = ctrl_q;
            TxdataOffset:   rd_mux = txdata_q;
            PrescaleOffset: rd_mux = prescale_q;
            AuxOffset:      rd_mux = aux_q;
            StatusOffset:   rd_mux = status;
            default:        rd_mux = '0;
        endcase

        ar_hs    = s00_axi_arvalid & arready_q;
        rvalid_d = rvalid_q & ~s00_axi_rready;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = RespOkay;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RespOkay;
    assign ctrl_reg        = ctrl_q;
    assign txdata_reg      = txdata_q;
    assign prescale_reg    = prescale_q;
    assign aux_reg         = aux_q;
    assign start_pulse     = start_q;

endmodule

// File: tb/tb_i2c_regs_axil_slave.sv
// Scoreboard bench for i2c_regs_axil_slave: stimulus queues expected B/R beats,
// a negedge monitor pops and compares them as the DUT completes handshakes.
module tb_i2c_regs_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] ctrl_reg, txdata_reg, prescale_reg, aux_reg;
    logic        start_pulse, i2c_busy, i2c_ack_err;
    logic [7:0]  i2c_rx_data;

    int          n_vec = 0;
    int          n_bad = 0;
    int          pulse_cnt = 0;
    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];

    always #5 clk = ~clk;

    i2c_regs_axil_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_reg        (ctrl_reg),
        .txdata_reg      (txdata_reg),
        .prescale_reg    (prescale_reg),
        .aux_reg         (aux_reg),
        .start_pulse     (start_pulse),
        .i2c_busy        (i2c_busy),
        .i2c_ack_err     (i2c_ack_err),
        .i2c_rx_data     (i2c_rx_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (start_pulse) pulse_cnt++;
        if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL b_unexpected: got bresp %0d, expected no response", bresp);
            end else begin
                check("bresp", {30'b0, bresp}, {30'b0, exp_b.pop_front()});
            end
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL r_unexpected: got rdata 0x%08h, expected no response", rdata);
            end else begin
                check("rdata", rdata, exp_r.pop_front());
                check("rresp", {30'b0, rresp}, 32'h0);
            end
        end
    end

    task automatic issue_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ag, wg;
        exp_b.push_back(2'b00);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            @(negedge clk);
            ag = awvalid && awready;
            wg = wvalid && wready;
            @(posedge clk); #1;
            if (ag) awvalid = 1'b0;
            if (wg) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            timeout("write_accept");
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic wait_b();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = bvalid && bready;
            @(posedge clk); #1;
        end
        if (!done) timeout("b_wait");
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        issue_write(a, d, s);
        wait_b();
    endtask

    task automatic ar_accept(input logic [4:0] a);
        bit done = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!done) timeout("ar_accept");
    endtask

    task automatic r_wait();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = rvalid && rready;
            @(posedge clk); #1;
        end
        if (!done) timeout("r_wait");
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] e);
        exp_r.push_back(e);
        ar_accept(a);
        r_wait();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {26'b0, awready, wready, arready, bvalid, rvalid, start_pulse}, 32'h0);
        check({name, "_regs"}, ctrl_reg | txdata_reg | prescale_reg | aux_reg, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        i2c_busy = 1'b0; i2c_ack_err = 1'b0; i2c_rx_data = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", {29'b0, awready, wready, arready}, 32'h7);
        @(posedge clk); #1;

        // Basic write / readback
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h00, 32'h1);
        axi_read(5'h04, 32'h2);
        axi_read(5'h08, 32'h3);
        axi_read(5'h0C, 32'h4);

        // W three cycles ahead of AW, partial strobes, B held off for 10 cycles
        bready = 1'b0;
        exp_b.push_back(2'b00);
        wdata = 32'hA5A5A5A5; wstrb = 4'h5; wvalid = 1'b1;
        @(negedge clk);
        check("w_first_wready", {31'b0, wready}, 32'h1);
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("w_held_flags", {29'b0, wready, awready, bvalid}, 32'h2);
        @(posedge clk); #1 awaddr = 5'h04; awvalid = 1'b1;
        @(negedge clk);
        check("aw_ready", {31'b0, awready}, 32'h1);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        check("bvalid_after_aw", {31'b0, bvalid}, 32'h1);
        check("txdata_strb", txdata_reg, 32'h00A500A5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b_hold", {29'b0, bvalid, awready, wready}, 32'h4);
        end
        @(posedge clk); #1 bready = 1'b1;
        wait_b();
        axi_read(5'h04, 32'h00A500A5);

        // R held off for 10 cycles
        rready = 1'b0;
        exp_r.push_back(32'h00A500A5);
        ar_accept(5'h04);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("r_hold_flags", {30'b0, rvalid, arready}, 32'h2);
            check("r_hold_data", rdata, 32'h00A500A5);
        end
        @(posedge clk); #1 rready = 1'b1;
        r_wait();

        // Start strobe
        i2c_busy = 1'b0; p0 = pulse_cnt;
        axi_write(5'h00, 32'h1, 4'hF);
        check("start_pulse_idle", pulse_cnt - p0, 32'd1);
        i2c_busy = 1'b1; p0 = pulse_cnt;
        axi_write(5'h00, 32'h1, 4'hF);
        check("start_pulse_busy", pulse_cnt - p0, 32'd0);
        axi_read(5'h00, 32'h1);
        i2c_busy = 1'b0; p0 = pulse_cnt;
        axi_write(5'h00, 32'h1, 4'hE);
        axi_write(5'h00, 32'h2, 4'hF);
        check("start_pulse_nolane", pulse_cnt - p0, 32'd0);
        check("ctrl_reg", ctrl_reg, 32'h2);

        // STATUS, unmapped offsets, ignored low address bits
        i2c_rx_data = 8'h3C; i2c_busy = 1'b1; i2c_ack_err = 1'b1;
        axi_read(5'h10, 32'h0000033C);
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF);
        axi_write(5'h14, 32'hDEADBEEF, 4'hF);
        axi_read(5'h14, 32'h0);
        axi_read(5'h1C, 32'h0);
        axi_read(5'h10, 32'h0000033C);
        check("regs_after_unmapped", ctrl_reg ^ txdata_reg ^ prescale_reg ^ aux_reg,
              32'h2 ^ 32'h00A500A5 ^ 32'h3 ^ 32'h4);
        axi_read(5'h0B, 32'h3);
        axi_write(5'h0E, 32'h000000AA, 4'h1);
        check("aux_low_addr", aux_reg, 32'h000000AA);
        i2c_rx_data = 8'h5A; i2c_busy = 1'b0; i2c_ack_err = 1'b0;
        axi_read(5'h10, 32'h0000005A);

        // Reset with AW latched and W still pending
        awaddr = 5'h08; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        @(negedge clk);
        check("aw_ready_pre_reset", {31'b0, awready}, 32'h1);
        @(posedge clk); #1 awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rerelease", {28'b0, awready, wready, arready, bvalid}, 32'he);
        @(posedge clk); #1;
        axi_read(5'h00, 32'h0);
        axi_read(5'h04, 32'h0);
        axi_read(5'h08, 32'h0);
        axi_read(5'h0C, 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_b.size() + exp_r.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
